// File: rtl/axba_pkg.sv
// Shared AXBA serializer types: block geometry, repeat-mask type and serializer FSM states.
package axba_pkg;
  localparam int AXBA_WORDS = 8;
  localparam int AXBA_WIDTH = 32;

  typedef logic [AXBA_WORDS-1:0][AXBA_WIDTH-1:0] axba_block_t;
  typedef logic [AXBA_WORDS-1:0]                 axba_mask_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } axba_ser_state_e;
endpackage

// File: rtl/axba_repeat_mask.sv
// Combinational repeat detector: flags words equal to their predecessor and finds
// the lowest and highest indices that still have to be transmitted.
module axba_repeat_mask
  import axba_pkg::*;
#(
  parameter int WORDS = AXBA_WORDS,
  parameter int WIDTH = AXBA_WIDTH,
  parameter int IW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic [WORDS-1:0][WIDTH-1:0] i_words,
  output logic [WORDS-1:0]            o_mask,
  output logic [IW-1:0]               o_first_idx,
  output logic [IW-1:0]               o_last_idx
);
  logic [WORDS-1:0] w_mask;
  logic [IW-1:0]    w_first;
  logic [IW-1:0]    w_last;

  // Word 0 never has a predecessor, so it is always sent.
  always_comb begin
    w_mask  = {WORDS{1'b0}};
    w_first = {IW{1'b0}};
    w_last  = {IW{1'b0}};
    for (int i = 1; i < WORDS; i++) begin
      w_mask[i] = (i_words[i] == i_words[i-1]);
    end
    for (int i = WORDS - 1; i >= 0; i--) begin
      w_first = w_mask[i] ? w_first : IW'(i);
    end
    for (int i = 0; i < WORDS; i++) begin
      w_last = w_mask[i] ? w_last : IW'(i);
    end
  end

  assign o_mask      = w_mask;
  assign o_first_idx = w_first;
  assign o_last_idx  = w_last;
endmodule

// File: rtl/axba_block_serializer.sv
// AXBA block serializer: takes one block per handshake, emits a repeat-mask header beat
// followed by the non-repeated words. Optional macro AXBA_SER_STATS_EN adds elided_words.
module axba_block_serializer
  import axba_pkg::*;
#(
  parameter int WORDS = AXBA_WORDS,
  parameter int WIDTH = AXBA_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        blk_valid,
  output logic                        blk_ready,
  input  logic [WORDS-1:0][WIDTH-1:0] blk_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [WIDTH-1:0]            tx_data,
  output logic                        tx_hdr,
  output logic                        tx_last,
  output logic                        busy,
  output logic [15:0]                 blocks_sent
`ifdef AXBA_SER_STATS_EN
  ,
  output logic [31:0]                 elided_words
`endif
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  axba_ser_state_e            r_state, w_state_nxt;
  logic [WORDS-1:0][WIDTH-1:0] r_block, w_block_nxt;
  logic [WORDS-1:0]           r_mask, w_mask_nxt, w_mask;
  logic [IW-1:0]              r_first, w_first_nxt, w_first;
  logic [IW-1:0]              r_last, w_last_nxt, w_last;
  logic [IW-1:0]              r_ptr, w_ptr_nxt, w_ptr_step;
  logic                       r_blk_ready, w_blk_ready_nxt;
  logic                       r_busy, w_busy_nxt;
  logic                       r_tx_valid, w_tx_valid_nxt;
  logic [WIDTH-1:0]           r_tx_data, w_tx_data_nxt;
  logic                       r_tx_hdr, w_tx_hdr_nxt;
  logic                       r_tx_last, w_tx_last_nxt;
  logic [15:0]                r_blocks_sent, w_blocks_nxt;

  axba_repeat_mask #(.WORDS(WORDS), .WIDTH(WIDTH), .IW(IW)) u_mask (
    .i_words     (blk_data),
    .o_mask      (w_mask),
    .o_first_idx (w_first),
    .o_last_idx  (w_last)
  );

  // Next payload index: lowest unmasked word above the current pointer.
  always_comb begin
    w_ptr_step = r_ptr;
    for (int i = WORDS - 1; i >= 0; i--) begin
      w_ptr_step = ((i > int'(r_ptr)) && !r_mask[i]) ? IW'(i) : w_ptr_step;
    end
  end

  // Serializer next-state and registered-output values.
  always_comb begin
    w_state_nxt     = r_state;
    w_block_nxt     = r_block;
    w_mask_nxt      = r_mask;
    w_first_nxt     = r_first;
    w_last_nxt      = r_last;
    w_ptr_nxt       = r_ptr;
    w_blk_ready_nxt = r_blk_ready;
    w_busy_nxt      = r_busy;
    w_tx_valid_nxt  = r_tx_valid;
    w_tx_data_nxt   = r_tx_data;
    w_tx_hdr_nxt    = r_tx_hdr;
    w_tx_last_nxt   = r_tx_last;
    w_blocks_nxt    = r_blocks_sent;
    case (r_state)
      IDLE: begin
        if (blk_valid && r_blk_ready) begin
          w_state_nxt     = HDR;
          w_block_nxt     = blk_data;
          w_mask_nxt      = w_mask;
          w_first_nxt     = w_first;
          w_last_nxt      = w_last;
          w_blk_ready_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
          w_tx_valid_nxt  = 1'b1;
          w_tx_hdr_nxt    = 1'b1;
          w_tx_last_nxt   = 1'b0;
          w_tx_data_nxt   = WIDTH'(w_mask);
        end else begin
          w_blk_ready_nxt = 1'b1;
        end
      end
      HDR: begin
        if (r_tx_valid && tx_ready) begin
          w_state_nxt   = PAY;
          w_ptr_nxt     = r_first;
          w_tx_hdr_nxt  = 1'b0;
          w_tx_data_nxt = r_block[r_first];
          w_tx_last_nxt = (r_first == r_last);
        end else begin
          w_state_nxt = r_state;
        end
      end
      PAY: begin
        if (r_tx_valid && tx_ready && r_tx_last) begin
          w_state_nxt     = IDLE;
          w_blocks_nxt    = r_blocks_sent + 16'd1;
          w_blk_ready_nxt = 1'b1;
          w_busy_nxt      = 1'b0;
          w_tx_valid_nxt  = 1'b0;
          w_tx_last_nxt   = 1'b0;
          w_tx_data_nxt   = {WIDTH{1'b0}};
        end else if (r_tx_valid && tx_ready) begin
          w_ptr_nxt     = w_ptr_step;
          w_tx_data_nxt = r_block[w_ptr_step];
          w_tx_last_nxt = (w_ptr_step == r_last);
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_blk_ready_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_tx_valid_nxt  = 1'b0;
        w_tx_hdr_nxt    = 1'b0;
        w_tx_last_nxt   = 1'b0;
        w_tx_data_nxt   = {WIDTH{1'b0}};
      end
    endcase
  end

  // State register; reset drops any held block at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_block       <= {(WORDS*WIDTH){1'b0}};
      r_mask        <= {WORDS{1'b0}};
      r_first       <= {IW{1'b0}};
      r_last        <= {IW{1'b0}};
      r_ptr         <= {IW{1'b0}};
      r_blk_ready   <= 1'b0;
      r_busy        <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= {WIDTH{1'b0}};
      r_tx_hdr      <= 1'b0;
      r_tx_last     <= 1'b0;
      r_blocks_sent <= 16'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_block       <= w_block_nxt;
      r_mask        <= w_mask_nxt;
      r_first       <= w_first_nxt;
      r_last        <= w_last_nxt;
      r_ptr         <= w_ptr_nxt;
      r_blk_ready   <= w_blk_ready_nxt;
      r_busy        <= w_busy_nxt;
      r_tx_valid    <= w_tx_valid_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_hdr      <= w_tx_hdr_nxt;
      r_tx_last     <= w_tx_last_nxt;
      r_blocks_sent <= w_blocks_nxt;
    end
  end

  assign blk_ready   = r_blk_ready;
  assign busy        = r_busy;
  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_tx_data;
  assign tx_hdr      = r_tx_hdr;
  assign tx_last     = r_tx_last;
  assign blocks_sent = r_blocks_sent;

`ifdef AXBA_SER_STATS_EN
  logic [32:0] w_elided_sum;
  logic        w_hdr_fire;
  logic [31:0] r_elided;

  assign w_hdr_fire = (r_state == HDR) && r_tx_valid && tx_ready;

  // Popcount of the held mask added to the running total; one spare bit detects overflow.
  always_comb begin
    w_elided_sum = {1'b0, r_elided};
    for (int i = 0; i < WORDS; i++) begin
      w_elided_sum = w_elided_sum + {32'd0, r_mask[i]};
    end
  end

  // Saturating elided-word counter, bumped once per header handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_elided <= 32'd0;
    end else if (w_hdr_fire) begin
      r_elided <= w_elided_sum[32] ? 32'hFFFF_FFFF : w_elided_sum[31:0];
    end else begin
      r_elided <= r_elided;
    end
  end

  assign elided_words = r_elided;
`endif
endmodule

// File: tb/tb_axba_block_serializer.sv
// Self-checking bench for axba_block_serializer: a bench-side model fills a scoreboard
// of expected beats at each block handshake; observed beats are compared per scenario.
module tb_axba_block_serializer;
  import axba_pkg::*;

  typedef struct packed {
    logic        hdr;
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        blk_valid;
  logic        blk_ready;
  axba_block_t blk_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        tx_hdr;
  logic        tx_last;
  logic        busy;
  logic [15:0] blocks_sent;
`ifdef AXBA_SER_STATS_EN
  logic [31:0] elided_words;
`endif

  axba_block_serializer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .blk_data    (blk_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_hdr      (tx_hdr),
    .tx_last     (tx_last),
    .busy        (busy),
    .blocks_sent (blocks_sent)
`ifdef AXBA_SER_STATS_EN
    ,
    .elided_words(elided_words)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          stab_viol = 0;
  int          ready_viol = 0;
  int          timeouts = 0;
  beat_t       exp_q[$];
  beat_t       obs_q[$];
  axba_block_t src_q[$];
  int          gaps[$];
  int          hdr_lat[$];

  function automatic axba_block_t mk_blk(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
    return {w7, w6, w5, w4, w3, w2, w1, w0};
  endfunction

  // Reference model: header carries the repeat mask, then every non-repeated word in order.
  function automatic void push_expected(input axba_block_t b);
    logic [7:0] m = 8'h00;
    int         last = 0;
    beat_t      bt;
    for (int i = 1; i < 8; i++) m[i] = (b[i] == b[i-1]);
    for (int i = 0; i < 8; i++) if (!m[i]) last = i;
    bt = {1'b1, 1'b0, 24'd0, m};
    exp_q.push_back(bt);
    for (int i = 0; i < 8; i++) begin
      if (!m[i]) begin
        bt = {1'b0, 1'(i == last), b[i]};
        exp_q.push_back(bt);
      end
    end
  endfunction

  task automatic run_traffic(input bit stall, input int budget);
    int    cyc = 0;
    int    last_cyc = -1;
    int    hs_cyc = 0;
    bit    pend = 1'b0;
    beat_t held = '0;
    beat_t cur;
    stab_viol = 0; ready_viol = 0;
    gaps.delete(); hdr_lat.delete(); exp_q.delete(); obs_q.delete();
    while ((src_q.size() > 0 || obs_q.size() < exp_q.size()) && cyc < budget) begin
      @(negedge clk);
      blk_valid = (src_q.size() > 0);
      blk_data  = blk_valid ? src_q[0] : {(AXBA_WORDS*AXBA_WIDTH){1'b0}};
      tx_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      cur = {tx_hdr, tx_last, tx_data};
      if (pend && (!tx_valid || cur !== held)) stab_viol++;
      if ((busy || tx_valid) && blk_ready) ready_viol++;
      if (tx_valid && tx_ready) begin
        obs_q.push_back(cur);
        pend = 1'b0;
        if (tx_hdr) hdr_lat.push_back(cyc - hs_cyc);
        if (tx_last) last_cyc = cyc;
      end else begin
        pend = tx_valid;
        held = cur;
      end
      if (blk_valid && blk_ready) begin
        push_expected(src_q[0]);
        void'(src_q.pop_front());
        if (last_cyc >= 0) gaps.push_back(cyc - last_cyc);
        hs_cyc = cyc;
      end
      cyc++;
    end
    if (cyc >= budget) timeouts++;
    @(negedge clk);
    blk_valid = 1'b0;
    tx_ready  = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; blk_valid = 1'b0; tx_ready = 1'b1;
    blk_data = {(AXBA_WORDS*AXBA_WIDTH){1'b0}};
    #3;
    checks++;
    if ({blk_ready, tx_valid, tx_hdr, tx_last, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {blk_ready, tx_valid, tx_hdr, tx_last, busy});
    end
    checks++;
    if (tx_data !== 32'd0 || blocks_sent !== 16'd0) begin
      errors++; $display("FAIL reset_data: tx_data %h blocks_sent %h want 0", tx_data, blocks_sent);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (blk_ready !== 1'b0) begin errors++; $display("FAIL ready_early: got %b want 0", blk_ready); end
    @(negedge clk);
    checks++;
    if (blk_ready !== 1'b1 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL ready_rise: blk_ready %b tx_valid %b want 1 0", blk_ready, tx_valid);
    end
  endtask

  task automatic test_incrementing();
    logic [15:0] bs0 = blocks_sent;
    beat_t       want;
    src_q.push_back(mk_blk(32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17));
    run_traffic(1'b0, 100);
    checks++;
    if (obs_q.size() !== 9) begin errors++; $display("FAIL inc_beats: got %0d want 9", obs_q.size()); end
    for (int i = 0; i < 9; i++) begin
      want = (i == 0) ? {1'b1, 1'b0, 32'h0} : {1'b0, 1'(i == 8), 32'(32'h10 + i - 1)};
      checks++;
      if (obs_q[i] !== want) begin errors++; $display("FAIL inc_beat%0d: got %h want %h", i, obs_q[i], want); end
    end
    checks++;
    if (hdr_lat.size() !== 1 || hdr_lat[0] !== 1) begin errors++; $display("FAIL hdr_latency: got %0d want 1", hdr_lat[0]); end
    checks++;
    if (blocks_sent !== 16'(bs0 + 16'd1)) begin errors++; $display("FAIL inc_count: got %0d want %0d", blocks_sent, bs0 + 16'd1); end
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL inc_idle: tx_valid %b busy %b want 0 0", tx_valid, busy); end
  endtask

  task automatic test_all_same();
    logic [15:0] bs0 = blocks_sent;
`ifdef AXBA_SER_STATS_EN
    logic [31:0] el0 = elided_words;
`endif
    src_q.push_back(mk_blk(32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555,
                           32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555));
    run_traffic(1'b0, 100);
    checks++;
    if (obs_q.size() !== 2) begin errors++; $display("FAIL same_beats: got %0d want 2", obs_q.size()); end
    checks++;
    if (obs_q[0] !== {1'b1, 1'b0, 32'h000000FE}) begin errors++; $display("FAIL same_hdr: got %h want FE header", obs_q[0]); end
    checks++;
    if (obs_q[1] !== {1'b0, 1'b1, 32'hAAAA5555}) begin errors++; $display("FAIL same_pay: got %h want last AAAA5555", obs_q[1]); end
    checks++;
    if (blocks_sent !== 16'(bs0 + 16'd1)) begin errors++; $display("FAIL same_count: got %0d want %0d", blocks_sent, bs0 + 16'd1); end
`ifdef AXBA_SER_STATS_EN
    checks++;
    if (elided_words !== el0 + 32'd7) begin errors++; $display("FAIL elided: got %0d want %0d", elided_words, el0 + 32'd7); end
`endif
  endtask

  task automatic test_mixed();
    beat_t want [5];
    want[0] = {1'b1, 1'b0, 32'h0000009A};
    want[1] = {1'b0, 1'b0, 32'd1};
    want[2] = {1'b0, 1'b0, 32'd2};
    want[3] = {1'b0, 1'b0, 32'd3};
    want[4] = {1'b0, 1'b1, 32'd1};
    src_q.push_back(mk_blk(32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd3, 32'd1, 32'd1));
    run_traffic(1'b0, 100);
    checks++;
    if (obs_q.size() !== 5) begin errors++; $display("FAIL mix_beats: got %0d want 5", obs_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin errors++; $display("FAIL mix_beat%0d: got %h want %h", i, obs_q[i], want[i]); end
    end
  endtask

  task automatic test_stall();
    src_q.push_back(mk_blk(32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd3, 32'd1, 32'd1));
    run_traffic(1'b1, 300);
    checks++;
    if (stab_viol !== 0) begin errors++; $display("FAIL stall_stable: got %0d violations want 0", stab_viol); end
    checks++;
    if (ready_viol !== 0) begin errors++; $display("FAIL stall_ready: got %0d violations want 0", ready_viol); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    int pay = 0;
    bit hit = 1'b0;
    blk_data  = mk_blk(32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17);
    blk_valid = 1'b1;
    tx_ready  = 1'b1;
    while (!hit && cyc < 50) begin
      @(negedge clk);
      if (busy) blk_valid = 1'b0;
      if (tx_valid && !tx_hdr) pay++;
      if (pay == 2) hit = 1'b1;
      cyc++;
    end
    checks++;
    if (!hit || tx_data !== 32'h11) begin errors++; $display("FAIL mid_reach: got %h want second payload 11", tx_data); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({blk_ready, tx_valid, tx_hdr, tx_last, busy} !== 5'b0 || tx_data !== 32'd0 || blocks_sent !== 16'd0) begin
      errors++; $display("FAIL mid_async: ctrl %b data %h count %h want all 0",
                         {blk_ready, tx_valid, tx_hdr, tx_last, busy}, tx_data, blocks_sent);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_hold: tx_valid %b want 0", tx_valid); end
    reset_n = 1'b1;
    @(negedge clk);
    src_q.push_back(mk_blk(32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd3, 32'd1, 32'd1));
    run_traffic(1'b0, 100);
    checks++;
    if (obs_q[0] !== {1'b1, 1'b0, 32'h0000009A} || obs_q.size() !== 5) begin
      errors++; $display("FAIL mid_restart: got first %h beats %0d want header 9A, 5 beats", obs_q[0], obs_q.size());
    end
    checks++;
    if (blocks_sent !== 16'd1) begin errors++; $display("FAIL mid_count: got %0d want 1", blocks_sent); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bs0 = blocks_sent;
    src_q.push_back(mk_blk(32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17));
    src_q.push_back(mk_blk(32'h5, 32'h5, 32'h5, 32'h5, 32'h5, 32'h5, 32'h5, 32'h5));
    src_q.push_back(mk_blk(32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd3, 32'd1, 32'd1));
    run_traffic(1'b0, 200);
    checks++;
    if (gaps.size() !== 2) begin errors++; $display("FAIL b2b_gapcnt: got %0d want 2", gaps.size()); end
    foreach (gaps[i]) begin
      checks++;
      if (gaps[i] !== 1) begin errors++; $display("FAIL b2b_gap%0d: got %0d cycles want 1", i, gaps[i]); end
    end
    checks++;
    if (obs_q.size() !== 16) begin errors++; $display("FAIL b2b_beats: got %0d want 16", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (blocks_sent !== 16'(bs0 + 16'd3)) begin errors++; $display("FAIL b2b_count: got %0d want %0d", blocks_sent, bs0 + 16'd3); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.r_blocks_sent = 16'hFFFF;
    @(negedge clk);
    release dut.r_blocks_sent;
    checks++;
    if (blocks_sent !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want FFFF", blocks_sent); end
    src_q.push_back(mk_blk(32'h7, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7));
    run_traffic(1'b0, 100);
    checks++;
    if (blocks_sent !== 16'h0000) begin errors++; $display("FAIL wrap: got %h want 0000", blocks_sent); end
  endtask

  initial begin
    test_reset();
    test_incrementing();
    test_all_same();
    test_mixed();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    checks++;
    if (timeouts !== 0) begin errors++; $display("FAIL timeout: got %0d expired waits want 0", timeouts); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
